// File: rtl/demux_4to1.sv
// Registered 1-to-4 demultiplexer: din is routed to y[sel], the other outputs are zero.
// All four outputs come straight from flops, so they cannot glitch.
module demux_4to1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3
);

    logic [3:0]            w_dec;
    logic [3:0][WIDTH-1:0] w_next;
    logic [3:0][WIDTH-1:0] r_y;

    // Unknown select decodes to no destination, so X never reaches the outputs.
    always_comb begin
        w_dec = 4'b0000;
        case (sel)
            2'b00:   w_dec = 4'b0001;
            2'b01:   w_dec = 4'b0010;
            2'b10:   w_dec = 4'b0100;
            2'b11:   w_dec = 4'b1000;
            default: w_dec = 4'b0000;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_next[g] = din & {WIDTH{w_dec[g]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_next;
        end
    end

    assign y0 = r_y[0];
    assign y1 = r_y[1];
    assign y2 = r_y[2];
    assign y3 = r_y[3];

endmodule

// File: tb/tb_demux_4to1.sv
// Bench for demux_4to1 (WIDTH=8): array-based reference model checked every falling
// edge, plus directed vectors with literal expectations.
module tb_demux_4to1;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [1:0] sel;
    logic [7:0] y0, y1, y2, y3;

    int errors = 0;
    int checks = 0;

    demux_4to1 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .sel   (sel),
        .y0    (y0),
        .y1    (y1),
        .y2    (y2),
        .y3    (y3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one slot per destination, addressed by the select value.
    logic [7:0] m [4];
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n)
                m[k] <= 8'h00;
            else
                m[k] <= (int'(sel) == k) ? din : 8'h00;
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
        chk({name, ".y0"}, y0, e0);
        chk({name, ".y1"}, y1, e1);
        chk({name, ".y2"}, y2, e2);
        chk({name, ".y3"}, y3, e3);
    endtask

    // Model compare on every falling edge, away from the capturing edge.
    always @(negedge clk) begin
        chk("model.y0", y0, m[0]);
        chk("model.y1", y1, m[1]);
        chk("model.y2", y2, m[2]);
        chk("model.y3", y3, m[3]);
    end

    // Apply inputs at a falling edge; they are captured at the next rising edge.
    task automatic tick(input logic [7:0] d, input logic [1:0] s);
        din = d;
        sel = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] onehot [4];
    logic [7:0] vd [6];
    logic [1:0] vs [6];

    initial begin
        onehot[0] = 4'b1000; onehot[1] = 4'b0100; onehot[2] = 4'b0010; onehot[3] = 4'b0001;
        vd[0] = 8'h5A; vs[0] = 2'd2;
        vd[1] = 8'hFF; vs[1] = 2'd0;
        vd[2] = 8'h80; vs[2] = 2'd3;
        vd[3] = 8'h00; vs[3] = 2'd1;
        vd[4] = 8'h01; vs[4] = 2'd1;
        vd[5] = 8'h3C; vs[5] = 2'd2;

        rst_n = 1'b0;
        din   = 8'h01;
        sel   = 2'b01;
        #1;
        chk4("reset_init", 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk4("reset_hold", 8'h00, 8'h00, 8'h00, 8'h00);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk4("release", 8'h00, 8'h01, 8'h00, 8'h00);

        for (int s = 0; s < 4; s++) begin
            tick(8'h01, 2'(s));
            chk4("sweep", {7'd0, onehot[s][3]}, {7'd0, onehot[s][2]},
                 {7'd0, onehot[s][1]}, {7'd0, onehot[s][0]});
        end

        tick(8'h00, 2'b10);
        chk4("zero_data", 8'h00, 8'h00, 8'h00, 8'h00);

        tick(8'h01, 2'b00);
        chk4("lat_before", 8'h01, 8'h00, 8'h00, 8'h00);
        sel = 2'b11;
        #3;
        chk4("lat_between", 8'h01, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        chk4("lat_after", 8'h00, 8'h00, 8'h00, 8'h01);
        @(negedge clk);

        tick(8'h01, 2'b10);
        chk4("pre_async", 8'h00, 8'h00, 8'h01, 8'h00);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk4("async_drop", 8'h00, 8'h00, 8'h00, 8'h00);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk4("async_recover", 8'h00, 8'h00, 8'h01, 8'h00);
        @(negedge clk);

        tick(8'hA5, 2'b01);
        chk4("w8_sel1", 8'h00, 8'hA5, 8'h00, 8'h00);
        tick(8'hA5, 2'b11);
        chk4("w8_sel3", 8'h00, 8'h00, 8'h00, 8'hA5);

        // Back-to-back vectors with din and sel changing together.
        for (int i = 0; i < 6; i++) begin
            tick(vd[i], vs[i]);
            chk4("vec", (vs[i] == 2'd0) ? vd[i] : 8'h00, (vs[i] == 2'd1) ? vd[i] : 8'h00,
                 (vs[i] == 2'd2) ? vd[i] : 8'h00, (vs[i] == 2'd3) ? vd[i] : 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
